// File: rtl/mux_scan_ctrl_if.sv
// mux_scan_ctrl_if: signal bundle between the scan controller and the 4:1 select tree / host.
//   start - request one scan of all four channels
//   cont  - continuous mode, sampled only when a scan completes
//   mux_f - final output of the downstream 4:1 select tree
//   sel   - select lines; sel[0] picks within a pair, sel[1] picks the pair
//   data  - captured word, data[k] is the sample of channel k
//   busy  - scan in progress
//   done  - one-cycle pulse when data holds a freshly completed scan
// master: the controller side; slave: the host / tree side.
interface mux_scan_ctrl_if;
    logic       start;
    logic       cont;
    logic       mux_f;
    logic [0:1] sel;
    logic [0:3] data;
    logic       busy;
    logic       done;

    modport master (
        input  start,
        input  cont,
        input  mux_f,
        output sel,
        output data,
        output busy,
        output done
    );

    modport slave (
        output start,
        output cont,
        output mux_f,
        input  sel,
        input  data,
        input  busy,
        input  done
    );
endinterface

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: steps a 4:1 select tree through channels 0..3, dwelling SETTLE_CYCLES+1 cycles
// on each and capturing mux_f into data[k] on the last dwell cycle.
//   clk   - single clock, all state updates on its rising edge
//   rst_n - synchronous active-low reset
//   bus   - mux_scan_ctrl_if.master (start, cont, mux_f in; sel, data, busy, done out)
// All outputs come straight from flops.
module mux_scan_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input logic            clk,
    input logic            rst_n,
    mux_scan_ctrl_if.master bus
);

    // At least one bit even when SETTLE_CYCLES is 0.
    localparam int unsigned CntW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        StIdle,
        StDwell,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      k_q, k_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [0:3]      data_q, data_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                k_d   = 2'd0;
                cnt_d = '0;
                if (bus.start) begin
                    state_d = StDwell;
                    busy_d  = 1'b1;
                end
            end

            StDwell: begin
                busy_d = 1'b1;
                if (cnt_q == CntMax) begin
                    // Closing edge of this channel's dwell: capture and move on.
                    data_d[k_q] = bus.mux_f;
                    cnt_d       = '0;
                    if (k_q == 2'd3) begin
                        state_d = StDone;
                        k_d     = 2'd0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        k_d = k_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end

            StDone: begin
                k_d   = 2'd0;
                cnt_d = '0;
                // start is deliberately ignored here; only cont can chain a new scan.
                if (bus.cont) begin
                    state_d = StDwell;
                    busy_d  = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
                k_d     = 2'd0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            k_q     <= 2'd0;
            cnt_q   <= '0;
            data_q  <= 4'b0000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Channel index k = 2*sel[1] + sel[0].
    assign bus.sel[0] = k_q[0];
    assign bus.sel[1] = k_q[1];
    assign bus.data   = data_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
module tb_mux_scan_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mux_scan_ctrl_if bus2 ();
    mux_scan_ctrl_if bus0 ();

    // Tree inputs B[0..3] for each DUT; the tree itself is modelled as b[k].
    logic [0:3] b2;
    logic [0:3] b0;
    assign bus2.mux_f = b2[{bus2.sel[1], bus2.sel[0]}];
    assign bus0.mux_f = b0[{bus0.sel[1], bus0.sel[0]}];

    mux_scan_ctrl #(.SETTLE_CYCLES(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    mux_scan_ctrl #(.SETTLE_CYCLES(0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       rst_n;
        logic       start;
        logic       cont;
        logic [0:3] b;
        logic [1:0] k;
        logic       busy;
        logic       done;
        logic [0:3] data;
    } vec_t;

    localparam int NVec = 26;
    vec_t vecs[NVec];

    int n;
    int busy_low;

    initial begin
        // Applied before an edge; expectations are for the cycle after that edge.
        //            rst   st    cont  b        k     busy  done  data
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 4'b1010, 2'd0, 1'b0, 1'b0, 4'b0000}; // reset beats start
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 4'b1010, 2'd0, 1'b0, 1'b0, 4'b0000}; // cont alone: idle
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 4'b1010, 2'd0, 1'b1, 1'b0, 4'b0000}; // t0
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 4'b1010, 2'd0, 1'b1, 1'b0, 4'b0000};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 4'b1010, 2'd0, 1'b1, 1'b0, 4'b0000};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 4'b1010, 2'd1, 1'b1, 1'b0, 4'b1000}; // t0+3 sample ch0
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 4'b1010, 2'd1, 1'b1, 1'b0, 4'b1000};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 4'b1010, 2'd1, 1'b1, 1'b0, 4'b1000}; // start while busy
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 4'b1010, 2'd2, 1'b1, 1'b0, 4'b1000};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 4'b1010, 2'd2, 1'b1, 1'b0, 4'b1000};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 4'b1010, 2'd2, 1'b1, 1'b0, 4'b1000};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 4'b1010, 2'd3, 1'b1, 1'b0, 4'b1010}; // t0+9 sample ch2
        vecs[12] = '{1'b1, 1'b0, 1'b0, 4'b1010, 2'd3, 1'b1, 1'b0, 4'b1010};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 4'b1010, 2'd3, 1'b1, 1'b0, 4'b1010}; // held start
        vecs[14] = '{1'b1, 1'b1, 1'b0, 4'b1010, 2'd0, 1'b0, 1'b1, 4'b1010}; // done cycle t0+13
        vecs[15] = '{1'b1, 1'b1, 1'b0, 4'b1010, 2'd0, 1'b0, 1'b0, 4'b1010}; // back to idle
        vecs[16] = '{1'b1, 1'b1, 1'b0, 4'b1010, 2'd0, 1'b1, 1'b0, 4'b1010}; // held start re-accepted
        vecs[17] = '{1'b1, 1'b0, 1'b0, 4'b1010, 2'd0, 1'b1, 1'b0, 4'b1010};
        vecs[18] = '{1'b1, 1'b0, 1'b0, 4'b0101, 2'd0, 1'b1, 1'b0, 4'b1010};
        vecs[19] = '{1'b1, 1'b0, 1'b0, 4'b0101, 2'd1, 1'b1, 1'b0, 4'b0010}; // only data[0] moves
        vecs[20] = '{1'b1, 1'b0, 1'b0, 4'b0101, 2'd1, 1'b1, 1'b0, 4'b0010};
        vecs[21] = '{1'b1, 1'b0, 1'b0, 4'b0101, 2'd1, 1'b1, 1'b0, 4'b0010};
        vecs[22] = '{1'b1, 1'b0, 1'b0, 4'b0101, 2'd2, 1'b1, 1'b0, 4'b0110};
        vecs[23] = '{1'b0, 1'b0, 1'b0, 4'b0101, 2'd0, 1'b0, 1'b0, 4'b0000}; // reset mid-scan
        vecs[24] = '{1'b1, 1'b0, 1'b0, 4'b0101, 2'd0, 1'b0, 1'b0, 4'b0000};
        vecs[25] = '{1'b1, 1'b0, 1'b0, 4'b0101, 2'd0, 1'b0, 1'b0, 4'b0000};

        rst_n      = 1'b0;
        bus2.start = 1'b0;
        bus2.cont  = 1'b0;
        bus0.start = 1'b0;
        bus0.cont  = 1'b0;
        b2         = 4'b0000;
        b0         = 4'b0000;

        for (int i = 0; i < NVec; i++) begin
            rst_n      = vecs[i].rst_n;
            bus2.start = vecs[i].start;
            bus2.cont  = vecs[i].cont;
            b2         = vecs[i].b;
            tick();
            chk($sformatf("v%0d_k", i), 32'({bus2.sel[1], bus2.sel[0]}), 32'(vecs[i].k));
            chk($sformatf("v%0d_busy", i), 32'(bus2.busy), 32'(vecs[i].busy));
            chk($sformatf("v%0d_done", i), 32'(bus2.done), 32'(vecs[i].done));
            chk($sformatf("v%0d_data", i), 32'(bus2.data), 32'(vecs[i].data));
        end
        bus2.start = 1'b0;
        bus2.cont  = 1'b0;

        // SETTLE_CYCLES=0 DUT sat idle through the table with outputs at reset values.
        chk("s0_idle_busy", 32'(bus0.busy), 32'd0);
        chk("s0_idle_data", 32'(bus0.data), 32'd0);

        // New scan after mid-scan reset completes normally.
        b2         = 4'b0011;
        bus2.start = 1'b1;
        tick();
        bus2.start = 1'b0;
        n = 1;
        while (!bus2.done && n < 40) begin
            tick();
            n++;
        end
        chk("rescan_latency", 32'(n), 32'd13);
        chk("rescan_data", 32'(bus2.data), 32'(4'b0011));

        // Continuous mode: second scan chains straight off the done cycle.
        tick();
        bus2.cont  = 1'b1;
        b2         = 4'b1010;
        bus2.start = 1'b1;
        tick();
        bus2.start = 1'b0;
        n = 1;
        while (!bus2.done && n < 40) begin
            tick();
            n++;
        end
        chk("cont_first_latency", 32'(n), 32'd13);
        chk("cont_first_data", 32'(bus2.data), 32'(4'b1010));
        b2 = 4'b1100;
        busy_low = 0;
        tick();
        n = 1;
        while (!bus2.done && n < 40) begin
            if (!bus2.busy) busy_low++;
            tick();
            n++;
        end
        chk("cont_second_latency", 32'(n), 32'd13);
        chk("cont_busy_gaps", 32'(busy_low), 32'd0);
        chk("cont_second_data", 32'(bus2.data), 32'(4'b1100));
        chk("cont_done_busy", 32'(bus2.busy), 32'd0);
        bus2.cont = 1'b0;
        tick();
        chk("cont_stop_busy", 32'(bus2.busy), 32'd0);
        chk("cont_stop_done", 32'(bus2.done), 32'd0);
        tick();
        chk("cont_stop_idle", 32'(bus2.busy), 32'd0);

        // Zero settle: one cycle per channel, done in cycle t0+5.
        b0         = 4'b0111;
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        n = 1;
        while (!bus0.done && n < 40) begin
            if (n <= 4) chk($sformatf("s0_k_c%0d", n), 32'({bus0.sel[1], bus0.sel[0]}), 32'(n - 1));
            tick();
            n++;
        end
        chk("s0_latency", 32'(n), 32'd5);
        chk("s0_data", 32'(bus0.data), 32'(4'b0111));
        chk("s0_done_sel", 32'({bus0.sel[1], bus0.sel[0]}), 32'd0);
        tick();
        chk("s0_after_done", 32'(bus0.done), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
